// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and helpers for the mem_arb RAM-port arbiter.
//   - state_t      : sequencer states (IDLE / ACC / DONE)
//   - ACC_CYC_MIN  : shortest legal access length in clock cycles
//   - base_of()    : extracts one AW-wide slice of the packed client base map
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An access needs one setup cycle, at least one strobe cycle and one
    // hold cycle around the write enable.
    localparam int ACC_CYC_MIN = 3;

    // The base map is passed in zero-extended to a fixed width so that a
    // single function serves every NCLI/AW combination.
    localparam int BASE_MAP_W = 2048;
    localparam int BASE_W     = 64;

    function automatic logic [BASE_W-1:0] base_of(
        input logic [BASE_MAP_W-1:0] map,
        input int                    i,
        input int                    aw
    );
        logic [BASE_MAP_W-1:0] shifted;
        logic [BASE_W-1:0]     field_mask;
        shifted    = map >> (i * aw);
        field_mask = (BASE_W'(1) << aw) - BASE_W'(1);
        return shifted[BASE_W-1:0] & field_mask;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// arb_pick
//   Combinational request picker. Scans the eligible requests
//   (req_i & ~mask_i) starting at index start_i and wrapping modulo N;
//   the first set bit wins. Fixed priority is start_i = 0.
//   Ports:
//     req_i   [N]   request vector
//     mask_i  [N]   requests to ignore for this pick
//     start_i [IW]  index searched first
//     valid_o       a winner exists
//     grant_o [IW]  index of the winner (0 when valid_o is low)
module arb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic          valid_o,
    output logic [IW-1:0] grant_o
);

    logic [N-1:0] eligible;

    always_comb begin
        eligible = req_i & ~mask_i;
        valid_o  = 1'b0;
        grant_o  = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!valid_o && eligible[idx]) begin
                valid_o = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb
//   Serialises accesses from NCLI clients onto one byte-wide SRAM port.
//   Each grant runs ACC_CYC cycles with ram_ce high, followed by one DONE
//   cycle that pulses the winner's ack and re-arbitrates with that client
//   masked. All RAM-side outputs are registered.
//   Optional feature: define MEM_ARB_RR_EN for round-robin selection
//   (search starts one past the last grant); otherwise fixed priority,
//   lowest index first.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     cli_req_i  [NCLI]   per-client request
//     cli_we_i   [NCLI]   per-client write (1) / read (0)
//     cli_addr_i [NCLI*AW] packed client addresses
//     cli_dati_i [NCLI*DW] packed client write data
//     cli_ack_o  [NCLI]   one-cycle completion pulse
//     cli_dato_o [DW]     last read data, shared by all clients
//     ram_addr_o [AW]     physical RAM address (client addr | base)
//     ram_dati_o [DW]     write data to RAM
//     ram_dato_i [DW]     read data from RAM
//     ram_ce_o, ram_oe_o, ram_we_o  active-high RAM strobes
//     busy_o              high whenever the sequencer is not idle
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int                  NCLI     = 4,
    parameter int                  AW       = 23,
    parameter int                  DW       = 8,
    parameter int                  ACC_CYC  = 4,
    parameter logic [NCLI*AW-1:0]  CLI_BASE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCLI-1:0]      cli_req_i,
    input  logic [NCLI-1:0]      cli_we_i,
    input  logic [NCLI*AW-1:0]   cli_addr_i,
    input  logic [NCLI*DW-1:0]   cli_dati_i,
    output logic [NCLI-1:0]      cli_ack_o,
    output logic [DW-1:0]        cli_dato_o,
    output logic [AW-1:0]        ram_addr_o,
    output logic [DW-1:0]        ram_dati_o,
    input  logic [DW-1:0]        ram_dato_i,
    output logic                 ram_ce_o,
    output logic                 ram_oe_o,
    output logic                 ram_we_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(NCLI);
    localparam int CW = $clog2(ACC_CYC);

    generate
        if (ACC_CYC < ACC_CYC_MIN || NCLI < 2) begin : g_bad_cfg
            $error("mem_arb: ACC_CYC must be >= 3 and NCLI must be >= 2");
        end
    endgenerate

    // Per-client physical address and write data, unpacked once.
    logic [AW-1:0] base_arr [NCLI];
    logic [AW-1:0] addr_arr [NCLI];
    logic [DW-1:0] dati_arr [NCLI];

    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_cli
            assign base_arr[gi] = AW'(base_of(BASE_MAP_W'(CLI_BASE), gi, AW));
            assign addr_arr[gi] = cli_addr_i[gi*AW +: AW] | base_arr[gi];
            assign dati_arr[gi] = cli_dati_i[gi*DW +: DW];
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   g_q, g_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   dati_q, dati_d;
    logic [DW-1:0]   dato_q, dato_d;
    logic [NCLI-1:0] ack_q, ack_d;
    logic            ce_q, ce_d;
    logic            oe_q, oe_d;
    logic            rwe_q, rwe_d;

    logic [NCLI-1:0] pick_mask;
    logic [IW-1:0]   pick_start;
    logic            pick_valid;
    logic [IW-1:0]   pick_g;

    // The client acked in DONE is masked so a same-cycle re-request
    // cannot steal the very next grant.
    assign pick_mask = (state_q == DONE) ? (NCLI'(1) << g_q) : '0;

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign pick_start = (ptr_q == IW'(NCLI - 1)) ? '0 : (ptr_q + IW'(1));
`else
    assign pick_start = '0;
`endif

    arb_pick #(
        .N  (NCLI),
        .IW (IW)
    ) u_pick (
        .req_i   (cli_req_i),
        .mask_i  (pick_mask),
        .start_i (pick_start),
        .valid_o (pick_valid),
        .grant_o (pick_g)
    );

    // State and registered-output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            dati_q  <= '0;
            dato_q  <= '0;
            ack_q   <= '0;
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
            rwe_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= IW'(NCLI - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            dati_q  <= dati_d;
            dato_q  <= dato_d;
            ack_q   <= ack_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            rwe_q   <= rwe_d;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next state, grant latching and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        addr_d  = addr_q;
        we_d    = we_q;
        dati_d  = dati_q;
        dato_d  = dato_q;
`ifdef MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (pick_valid) begin
                    state_d = ACC;
                    cnt_d   = CW'(ACC_CYC - 1);
                    g_d     = pick_g;
                    addr_d  = addr_arr[pick_g];
                    we_d    = cli_we_i[pick_g];
                    dati_d  = dati_arr[pick_g];
`ifdef MEM_ARB_RR_EN
                    ptr_d   = pick_g;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        dato_d = ram_dato_i;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so strobes leave a flop.
    // The write strobe skips the first and last ACC cycles, giving one
    // cycle of address setup and one of hold around ram_we.
    always_comb begin
        ce_d  = (state_d == ACC);
        oe_d  = ce_d && !we_d;
        rwe_d = ce_d && we_d && (cnt_d != '0) && (cnt_d != CW'(ACC_CYC - 1));
        ack_d = (state_d == DONE) ? (NCLI'(1) << g_d) : '0;
    end

    assign cli_ack_o  = ack_q;
    assign cli_dato_o = dato_q;
    assign ram_addr_o = addr_q;
    assign ram_dati_o = dati_q;
    assign ram_ce_o   = ce_q;
    assign ram_oe_o   = oe_q;
    assign ram_we_o   = rwe_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb
//   Directed bench for mem_arb with NCLI=4, AW=23, DW=8, ACC_CYC=4 and
//   client 1 mapped at 0x400000. The RAM model answers reads with
//   ram_addr[7:0] ^ 0x79 (address 0x123 -> 0x5A). Build with
//   MEM_ARB_RR_EN to exercise the round-robin expectations.
module tb_mem_arb;

    localparam int NCLI = 4;
    localparam int AW   = 23;
    localparam int DW   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCLI-1:0]     req = '0;
    logic [NCLI-1:0]     we = '0;
    logic [NCLI*AW-1:0]  addr = '0;
    logic [NCLI*DW-1:0]  dati = '0;
    logic [NCLI-1:0]     ack;
    logic [DW-1:0]       dato;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_dati;
    logic [DW-1:0]       ram_dato;
    logic                ram_ce, ram_oe, ram_we, busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    assign ram_dato = ram_addr[7:0] ^ 8'h79;

    mem_arb #(
        .NCLI     (NCLI),
        .AW       (AW),
        .DW       (DW),
        .ACC_CYC  (4),
        .CLI_BASE ({23'h000000, 23'h000000, 23'h400000, 23'h000000})
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cli_req_i  (req),
        .cli_we_i   (we),
        .cli_addr_i (addr),
        .cli_dati_i (dati),
        .cli_ack_o  (ack),
        .cli_dato_o (dato),
        .ram_addr_o (ram_addr),
        .ram_dati_o (ram_dati),
        .ram_dato_i (ram_dato),
        .ram_ce_o   (ram_ce),
        .ram_oe_o   (ram_oe),
        .ram_we_o   (ram_we),
        .busy_o     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_cli(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        dati[i*DW +: DW]  = d;
        req[i]            = 1'b1;
    endtask

    // Runs one 5-cycle grant slot and checks the ack lands exactly on the
    // fifth cycle (one access per ACC_CYC+1 cycles).
    task automatic slot(input string tag, input logic [3:0] exp_ack);
        for (int k = 1; k <= 4; k++) tick();
        check_val({tag, "_noack"}, 32'(ack), 32'h0);
        tick();
        check_val({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_ce", 32'(ram_ce), 32'h0);
        check_val("rst_addr", 32'(ram_addr), 32'h0);
        check_val("rst_dato", 32'(dato), 32'h0);
        check_val("rst_ack", 32'(ack), 32'h0);
        do_reset();

        // Single read, client 0, addr 0x000123
        set_cli(0, 1'b0, 23'h000123, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val($sformatf("rd_ce_c%0d", c), 32'(ram_ce), 32'h1);
            check_val($sformatf("rd_oe_c%0d", c), 32'(ram_oe), 32'h1);
            check_val($sformatf("rd_we_c%0d", c), 32'(ram_we), 32'h0);
            check_val($sformatf("rd_addr_c%0d", c), 32'(ram_addr), 32'h000123);
            check_val($sformatf("rd_ack_c%0d", c), 32'(ack), 32'h0);
        end
        tick();
        check_val("rd_ack", 32'(ack), 32'h1);
        check_val("rd_dato", 32'(dato), 32'h5A);
        check_val("rd_ce_off", 32'(ram_ce), 32'h0);
        req[0] = 1'b0;
        tick();
        check_val("rd_idle_busy", 32'(busy), 32'h0);
        check_val("rd_idle_ack", 32'(ack), 32'h0);
        check_val("rd_idle_addr", 32'(ram_addr), 32'h000123);

        // Write, client 1, mapped base 0x400000
        set_cli(1, 1'b1, 23'h000010, 8'hC3);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_val($sformatf("wr_ce_c%0d", c), 32'(ram_ce), 32'h1);
            check_val($sformatf("wr_oe_c%0d", c), 32'(ram_oe), 32'h0);
            check_val($sformatf("wr_we_c%0d", c), 32'(ram_we), (c == 2 || c == 3) ? 32'h1 : 32'h0);
            check_val($sformatf("wr_addr_c%0d", c), 32'(ram_addr), 32'h400010);
            check_val($sformatf("wr_dati_c%0d", c), 32'(ram_dati), 32'hC3);
        end
        tick();
        check_val("wr_ack", 32'(ack), 32'h2);
        check_val("wr_dato_kept", 32'(dato), 32'h5A);
        req[1] = 1'b0;
        tick();
        check_val("wr_idle_busy", 32'(busy), 32'h0);

        // Priority: clients 0,2,3 together; client 0 re-requests after its ack
        do_reset();
        set_cli(0, 1'b0, 23'h000020, 8'h00);
        set_cli(2, 1'b0, 23'h000030, 8'h00);
        set_cli(3, 1'b0, 23'h000040, 8'h00);
        slot("pri_g1", 4'b0001);
        check_val("pri_g1_dato", 32'(dato), 32'h59);
        req[0] = 1'b0;
        tick();
        req[0] = 1'b1;
        for (int k = 2; k <= 4; k++) tick();
        check_val("pri_g2_noack", 32'(ack), 32'h0);
        tick();
        check_val("pri_g2_ack", 32'(ack), 32'h4);
        check_val("pri_g2_dato", 32'(dato), 32'h49);
        req[2] = 1'b0;
`ifdef MEM_ARB_RR_EN
        slot("pri_g3", 4'b1000);
        check_val("pri_g3_dato", 32'(dato), 32'h39);
        req[3] = 1'b0;
        slot("pri_g4", 4'b0001);
        check_val("pri_g4_dato", 32'(dato), 32'h59);
        req[0] = 1'b0;
`else
        slot("pri_g3", 4'b0001);
        check_val("pri_g3_dato", 32'(dato), 32'h59);
        req[0] = 1'b0;
        slot("pri_g4", 4'b1000);
        check_val("pri_g4_dato", 32'(dato), 32'h39);
        req[3] = 1'b0;
`endif
        tick();
        check_val("pri_idle_busy", 32'(busy), 32'h0);

        // All four clients requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) set_cli(i, 1'b0, 23'(32'h100 + i), 8'h00);
`ifdef MEM_ARB_RR_EN
        slot("all_g1", 4'b0001);
        slot("all_g2", 4'b0010);
        slot("all_g3", 4'b0100);
        slot("all_g4", 4'b1000);
        slot("all_g5", 4'b0001);
`else
        slot("all_g1", 4'b0001);
        slot("all_g2", 4'b0010);
        slot("all_g3", 4'b0001);
        slot("all_g4", 4'b0010);
        slot("all_g5", 4'b0001);
`endif
        req = '0;
        tick();
        check_val("all_idle_busy", 32'(busy), 32'h0);

        // Early drop: client 2 drops req in cycle 2 of its access
        do_reset();
        set_cli(2, 1'b0, 23'h000055, 8'h00);
        tick();
        tick();
        req[2] = 1'b0;
        tick();
        tick();
        check_val("drop_ce_c4", 32'(ram_ce), 32'h1);
        tick();
        check_val("drop_ack", 32'(ack), 32'h4);
        check_val("drop_dato", 32'(dato), 32'h2C);
        tick();
        check_val("drop_ack_off", 32'(ack), 32'h0);
        check_val("drop_busy", 32'(busy), 32'h0);

        // Reset in cycle 3 of a write by client 3
        do_reset();
        set_cli(3, 1'b1, 23'h000007, 8'h99);
        tick();
        tick();
        tick();
        check_val("rstw_we_c3", 32'(ram_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check_val("rstw_ce", 32'(ram_ce), 32'h0);
        check_val("rstw_we", 32'(ram_we), 32'h0);
        check_val("rstw_busy", 32'(busy), 32'h0);
        check_val("rstw_addr", 32'(ram_addr), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rstw_noack", 32'(ack), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("rstw_re_ce", 32'(ram_ce), 32'h1);
        check_val("rstw_re_addr", 32'(ram_addr), 32'h000007);
        check_val("rstw_re_we_c1", 32'(ram_we), 32'h0);
        tick();
        check_val("rstw_re_we_c2", 32'(ram_we), 32'h1);
        check_val("rstw_re_dati", 32'(ram_dati), 32'h99);
        tick();
        tick();
        check_val("rstw_re_noack", 32'(ack), 32'h0);
        tick();
        check_val("rstw_re_ack", 32'(ack), 32'h8);
        req[3] = 1'b0;
        tick();
        check_val("rstw_idle_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
